snoop_responder: RTL

//  Bus-side end of the MSI snooping protocol: consumes READ_MISS/WRITE_MISS/INVALIDATE messages

---
 rtl/coherence_pkg.sv | 30 +++
 rtl/sat_counter.sv | 34 +++
 rtl/snoop_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/coherence_pkg.sv
// -----------------------------------------------------------------------------
// coherence_pkg
// Shared encodings for the MSI snooping protocol:
//   - MSI line-state encodings (ST_I / ST_S / ST_M)
//   - snoop bus operation encodings
//   - snoop responder FSM state enum
// No ports; imported by the snoop responder and its sub-modules.
// -----------------------------------------------------------------------------
package coherence_pkg;

    // MSI line states as stored by the CPU side (2 bits per line)
    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    // Snoop bus operations
    localparam logic [1:0] OP_READ_MISS  = 2'b00;
    localparam logic [1:0] OP_WRITE_MISS = 2'b01;
    localparam logic [1:0] OP_INVALIDATE = 2'b10;
    localparam logic [1:0] OP_RESERVED   = 2'b11;

    // Snoop responder FSM
    typedef enum logic [1:0] {
        FSM_IDLE   = 2'b00,
        FSM_LOOKUP = 2'b01,
        FSM_WB     = 2'b10,
        FSM_UPDATE = 2'b11
    } snoop_fsm_e;

endpackage : coherence_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clock   in   1       posedge clock
//   reset_n in   1       asynchronous active-low reset (count -> 0)
//   inc     in   1       count one event this cycle
//   count   out  CNT_W   current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count register: increments on inc until it reaches all-ones
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule : sat_counter

// File: rtl/snoop_responder.sv
// -----------------------------------------------------------------------------
// snoop_responder
// Bus-side end of the MSI snooping protocol. Accepts READ_MISS / WRITE_MISS /
// INVALIDATE messages broadcast by other CPUs, looks up the local direct-mapped
// line, writes back Modified data and downgrades / invalidates line state.
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   bus_valid/bus_ready       snoop message handshake (ready only in IDLE)
//   bus_op/bus_addr/bus_src   message operation, address, originating CPU
//   line_state/tag/data       packed per-line cache contents from the CPU side
//   upd_valid/line/state      one-cycle line-state update strobe
//   wb_valid/ready/addr/data  write-back request to memory
//   abort_mem                 one-cycle pulse: requester's memory access aborts
//   busy                      responder not in IDLE
//   proto_err                 sticky: INVALIDATE found a Modified line
//   wb_count/inv_count        saturating statistics counters
// -----------------------------------------------------------------------------
module snoop_responder
    import coherence_pkg::*;
#(
    parameter int CPU_ID    = 0,
    parameter int ID_W      = 2,
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 4,
    parameter int NUM_LINES = 2,
    parameter int CNT_W     = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          bus_valid,
    output logic                          bus_ready,
    input  logic [1:0]                    bus_op,
    input  logic [ADDR_W-1:0]             bus_addr,
    input  logic [ID_W-1:0]               bus_src,
    input  logic [2*NUM_LINES-1:0]        line_state,
    input  logic [ADDR_W*NUM_LINES-1:0]   line_tag,
    input  logic [DATA_W*NUM_LINES-1:0]   line_data,
    output logic                          upd_valid,
    output logic [$clog2(NUM_LINES)-1:0]  upd_line,
    output logic [1:0]                    upd_state,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [ADDR_W-1:0]             wb_addr,
    output logic [DATA_W-1:0]             wb_data,
    output logic                          abort_mem,
    output logic                          busy,
    output logic                          proto_err,
    output logic [CNT_W-1:0]              wb_count,
    output logic [CNT_W-1:0]              inv_count
);

    localparam int IDX_W = $clog2(NUM_LINES);

    snoop_fsm_e          state_r, state_next_s;

    logic [1:0]          op_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [ID_W-1:0]     src_r;
    logic [ADDR_W-1:0]   wb_addr_r;
    logic [DATA_W-1:0]   wb_data_r;
    logic [IDX_W-1:0]    upd_line_r;
    logic [1:0]          upd_state_r;
    logic                abort_r;
    logic                proto_err_r;
    logic                bus_ready_r;
    logic                busy_r;
    logic                wb_valid_r;
    logic                upd_valid_r;

    logic [IDX_W-1:0]    idx_s;
    logic [1:0]          sel_state_s;
    logic [ADDR_W-1:0]   sel_tag_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                hit_s;
    logic                lk_wb_s;
    logic                lk_err_s;
    logic [1:0]          lk_tgt_s;
    logic                wb_done_s;
    logic                inv_inc_s;

    assign idx_s = addr_r[IDX_W-1:0];

    // Select the line addressed by the latched message
    always_comb begin
        sel_state_s = 2'b00;
        sel_tag_s   = '0;
        sel_data_s  = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            sel_state_s = (IDX_W'(i) == idx_s) ? line_state[2*i +: 2]          : sel_state_s;
            sel_tag_s   = (IDX_W'(i) == idx_s) ? line_tag[ADDR_W*i +: ADDR_W]  : sel_tag_s;
            sel_data_s  = (IDX_W'(i) == idx_s) ? line_data[DATA_W*i +: DATA_W] : sel_data_s;
        end
    end

    assign hit_s = (sel_tag_s == addr_r) && (sel_state_s != ST_I);

    // Next-state and lookup decisions
    always_comb begin
        state_next_s = state_r;
        lk_wb_s      = 1'b0;
        lk_err_s     = 1'b0;
        lk_tgt_s     = ST_I;
        case (state_r)
            FSM_IDLE: begin
                if (bus_valid) begin
                    state_next_s = FSM_LOOKUP;
                end else begin
                    state_next_s = FSM_IDLE;
                end
            end
            FSM_LOOKUP: begin
                state_next_s = FSM_IDLE;
                // Own messages, misses and the reserved op are dropped silently
                if ((src_r == ID_W'(CPU_ID)) || !hit_s || (op_r == OP_RESERVED)) begin
                    state_next_s = FSM_IDLE;
                end else begin
                    case (sel_state_s)
                        ST_S: begin
                            if (op_r == OP_READ_MISS) begin
                                state_next_s = FSM_IDLE;
                            end else begin
                                lk_tgt_s     = ST_I;
                                state_next_s = FSM_UPDATE;
                            end
                        end
                        ST_M: begin
                            case (op_r)
                                OP_READ_MISS: begin
                                    lk_wb_s      = 1'b1;
                                    lk_tgt_s     = ST_S;
                                    state_next_s = FSM_WB;
                                end
                                OP_WRITE_MISS: begin
                                    lk_wb_s      = 1'b1;
                                    lk_tgt_s     = ST_I;
                                    state_next_s = FSM_WB;
                                end
                                OP_INVALIDATE: begin
                                    // Another CPU believed it shared a line we hold
                                    // Modified: flag it, drop the line, no write-back.
                                    lk_err_s     = 1'b1;
                                    lk_tgt_s     = ST_I;
                                    state_next_s = FSM_UPDATE;
                                end
                                default: begin
                                    state_next_s = FSM_IDLE;
                                end
                            endcase
                        end
                        default: begin
                            state_next_s = FSM_IDLE;
                        end
                    endcase
                end
            end
            FSM_WB: begin
                if (wb_ready) begin
                    state_next_s = FSM_UPDATE;
                end else begin
                    state_next_s = FSM_WB;
                end
            end
            FSM_UPDATE: begin
                state_next_s = FSM_IDLE;
            end
            default: begin
                state_next_s = FSM_IDLE;
            end
        endcase
    end

    // FSM state register plus registered state-decoded outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= FSM_IDLE;
            bus_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            wb_valid_r  <= 1'b0;
            upd_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            bus_ready_r <= (state_next_s == FSM_IDLE);
            busy_r      <= (state_next_s != FSM_IDLE);
            wb_valid_r  <= (state_next_s == FSM_WB);
            upd_valid_r <= (state_next_s == FSM_UPDATE);
        end
    end

    // Message latch, write-back payload, update target, abort pulse, error flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_r        <= 2'b00;
            addr_r      <= '0;
            src_r       <= '0;
            wb_addr_r   <= '0;
            wb_data_r   <= '0;
            upd_line_r  <= '0;
            upd_state_r <= 2'b00;
            abort_r     <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            if ((state_r == FSM_IDLE) && bus_valid) begin
                op_r   <= bus_op;
                addr_r <= bus_addr;
                src_r  <= bus_src;
            end else begin
                op_r   <= op_r;
                addr_r <= addr_r;
                src_r  <= src_r;
            end
            if (state_r == FSM_LOOKUP) begin
                upd_line_r  <= idx_s;
                upd_state_r <= lk_tgt_s;
            end else begin
                upd_line_r  <= upd_line_r;
                upd_state_r <= upd_state_r;
            end
            if (lk_wb_s) begin
                wb_addr_r <= sel_tag_s;
                wb_data_r <= sel_data_s;
            end else begin
                wb_addr_r <= wb_addr_r;
                wb_data_r <= wb_data_r;
            end
            abort_r     <= lk_wb_s;
            proto_err_r <= proto_err_r | lk_err_s;
        end
    end

    assign wb_done_s = (state_r == FSM_WB) && wb_ready;
    assign inv_inc_s = (state_r == FSM_UPDATE) && (upd_state_r == ST_I);

    sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (wb_done_s),
        .count   (wb_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_inv_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (inv_inc_s),
        .count   (inv_count)
    );

    assign bus_ready = bus_ready_r;
    assign busy      = busy_r;
    assign wb_valid  = wb_valid_r;
    assign upd_valid = upd_valid_r;
    assign upd_line  = upd_line_r;
    assign upd_state = upd_state_r;
    assign wb_addr   = wb_addr_r;
    assign wb_data   = wb_data_r;
    assign abort_mem = abort_r;
    assign proto_err = proto_err_r;

endmodule : snoop_responder
